// File: rtl/io_write_predication_multi.sv
// I/O write predication for the multithreaded barrel datapath.
//
// Each instruction carries DEST_COUNT write destinations. Destinations that fall in the
// memory-mapped I/O port window report the EmptyFull status of their port one stage later.
// In the commit cycle, the global IO_ready annuls every I/O write enable and every port
// strobe. A saturating per-thread counter tracks consecutive annulled I/O writes so that
// threads starved by a full port can be flagged.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous active-high reset of all pipeline state and counters
//   enable           instruction valid and writing (stage 1)
//   addr             DEST_COUNT packed destination addresses, dest d at [d*ADDR_WIDTH +: ADDR_WIDTH]
//   thread_id        issuing thread (stage 1)
//   EmptyFull        per-port status, 1 = full (stage 1)
//   IO_ready         global ready, consumed in the commit cycle
//   EmptyFull_masked per-dest not-ready bit, registered (stage 2)
//   addr_is_IO       per-dest I/O write enable after annulment (commit)
//   port_wren        decoded per-port write strobes (commit)
//   annul_count      pre-update annul counter of the committing thread
//   starved          annul_count >= STARVE_LIMIT
module io_write_predication_multi #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DEST_COUNT      = 2,
  parameter int unsigned PORT_COUNT      = 8,
  parameter int unsigned PORT_BASE_ADDR  = 1016,
  parameter int unsigned PORT_ADDR_WIDTH = 3,
  parameter int unsigned ALIGN_STAGES    = 1,
  parameter int unsigned THREAD_COUNT    = 8,
  parameter int unsigned THREAD_ID_WIDTH = 3,
  parameter int unsigned CNT_WIDTH       = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [DEST_COUNT*ADDR_WIDTH-1:0] addr,
  input  logic [THREAD_ID_WIDTH-1:0]       thread_id,
  input  logic [PORT_COUNT-1:0]            EmptyFull,
  input  logic                             IO_ready,
  output logic [DEST_COUNT-1:0]            EmptyFull_masked,
  output logic [DEST_COUNT-1:0]            addr_is_IO,
  output logic [PORT_COUNT-1:0]            port_wren,
  output logic [CNT_WIDTH-1:0]             annul_count,
  output logic                             starved
);

  // Stage 2 plus the alignment registers.
  localparam int unsigned Depth = ALIGN_STAGES + 1;
  // Window bounds held in 64 bits: base + count may not fit in ADDR_WIDTH.
  localparam logic [63:0] WinLo = 64'(PORT_BASE_ADDR);
  localparam logic [63:0] WinHi = 64'(PORT_BASE_ADDR) + 64'(PORT_COUNT);
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  typedef logic [DEST_COUNT-1:0][PORT_ADDR_WIDTH-1:0] idx_vec_t;

  // Stage 1 decode.
  logic [DEST_COUNT-1:0] is_io_d;
  idx_vec_t              idx_d;

  always_comb begin
    is_io_d = '0;
    idx_d   = '0;
    for (int d = 0; d < DEST_COUNT; d++) begin
      is_io_d[d] = enable &&
                   (64'(addr[d*ADDR_WIDTH +: ADDR_WIDTH]) >= WinLo) &&
                   (64'(addr[d*ADDR_WIDTH +: ADDR_WIDTH]) <  WinHi);
      idx_d[d]   = addr[d*ADDR_WIDTH +: PORT_ADDR_WIDTH];
    end
  end

  logic [DEST_COUNT-1:0]      s1_is_io_q;
  idx_vec_t                   s1_idx_q;
  logic [PORT_COUNT-1:0]      s1_ef_q;
  logic [THREAD_ID_WIDTH-1:0] s1_tid_q;

  // Index 0 is stage 2; index Depth-1 is the commit cycle.
  logic [DEST_COUNT-1:0]      is_io_pipe_q [Depth];
  idx_vec_t                   idx_pipe_q   [Depth];
  logic [THREAD_ID_WIDTH-1:0] tid_pipe_q   [Depth];

  logic [DEST_COUNT-1:0] efm_d, efm_q;
  logic [CNT_WIDTH-1:0]  cnt_d [THREAD_COUNT];
  logic [CNT_WIDTH-1:0]  cnt_q [THREAD_COUNT];

  // Stage 2: a destination only blocks when it targets the window and its port is full.
  always_comb begin
    efm_d = '0;
    for (int d = 0; d < DEST_COUNT; d++) begin
      efm_d[d] = s1_is_io_q[d] ? s1_ef_q[s1_idx_q[d]] : 1'b0;
    end
  end

  // Commit cycle.
  logic [DEST_COUNT-1:0]      is_io_c;
  idx_vec_t                   idx_c;
  logic [THREAD_ID_WIDTH-1:0] tid_c;
  logic                       io_wr;

  assign is_io_c = is_io_pipe_q[Depth-1];
  assign idx_c   = idx_pipe_q[Depth-1];
  assign tid_c   = tid_pipe_q[Depth-1];
  assign io_wr   = |is_io_c;

  always_comb begin
    addr_is_IO = is_io_c & {DEST_COUNT{IO_ready}};
    port_wren  = '0;
    // Destinations aliasing the same port collapse into one strobe.
    for (int p = 0; p < PORT_COUNT; p++) begin
      for (int d = 0; d < DEST_COUNT; d++) begin
        if (addr_is_IO[d] && (idx_c[d] == PORT_ADDR_WIDTH'(p))) begin
          port_wren[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    annul_count = cnt_q[tid_c];
    starved     = (32'(cnt_q[tid_c]) >= STARVE_LIMIT);
    cnt_d       = cnt_q;
    if (io_wr) begin
      if (IO_ready) begin
        cnt_d[tid_c] = '0;
      end else if (cnt_q[tid_c] != CntMax) begin
        cnt_d[tid_c] = cnt_q[tid_c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_is_io_q <= '0;
      s1_idx_q   <= '0;
      s1_ef_q    <= '0;
      s1_tid_q   <= '0;
      efm_q      <= '0;
      for (int i = 0; i < Depth; i++) begin
        is_io_pipe_q[i] <= '0;
        idx_pipe_q[i]   <= '0;
        tid_pipe_q[i]   <= '0;
      end
      for (int k = 0; k < THREAD_COUNT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      s1_is_io_q      <= is_io_d;
      s1_idx_q        <= idx_d;
      s1_ef_q         <= EmptyFull;
      s1_tid_q        <= thread_id;
      efm_q           <= efm_d;
      is_io_pipe_q[0] <= s1_is_io_q;
      idx_pipe_q[0]   <= s1_idx_q;
      tid_pipe_q[0]   <= s1_tid_q;
      for (int i = 1; i < Depth; i++) begin
        is_io_pipe_q[i] <= is_io_pipe_q[i-1];
        idx_pipe_q[i]   <= idx_pipe_q[i-1];
        tid_pipe_q[i]   <= tid_pipe_q[i-1];
      end
      cnt_q <= cnt_d;
    end
  end

  assign EmptyFull_masked = efm_q;

endmodule

// File: tb/tb_io_write_predication_multi.sv
module tb_io_write_predication_multi;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [19:0] addr;
  logic [2:0]  thread_id;
  logic [7:0]  EmptyFull;
  logic        IO_ready;

  logic [1:0] efm_a, aio_a, efm_b, aio_b;
  logic [7:0] wren_a, wren_b;
  logic [3:0] cnt_out_a;
  logic [1:0] cnt_out_b;
  logic       starved_a, starved_b;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Default configuration.
  io_write_predication_multi dut_a (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .addr             (addr),
    .thread_id        (thread_id),
    .EmptyFull        (EmptyFull),
    .IO_ready         (IO_ready),
    .EmptyFull_masked (efm_a),
    .addr_is_IO       (aio_a),
    .port_wren        (wren_a),
    .annul_count      (cnt_out_a),
    .starved          (starved_a)
  );

  // Small counter with a low starvation limit, fed the same stimulus.
  io_write_predication_multi #(
    .CNT_WIDTH    (2),
    .STARVE_LIMIT (3)
  ) dut_b (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .addr             (addr),
    .thread_id        (thread_id),
    .EmptyFull        (EmptyFull),
    .IO_ready         (IO_ready),
    .EmptyFull_masked (efm_b),
    .addr_is_IO       (aio_b),
    .port_wren        (wren_b),
    .annul_count      (cnt_out_b),
    .starved          (starved_b)
  );

  // Reference model: instructions issued 1, 2 and 3 cycles ago, plus per-thread counts.
  typedef struct {
    logic       en;
    logic [9:0] a0;
    logic [9:0] a1;
    logic [2:0] tid;
    logic [7:0] ef;
  } instr_t;

  instr_t hist [3];
  int     cnt_a [8];
  int     cnt_b [8];

  function automatic instr_t bubble();
    instr_t b;
    b.en = 1'b0; b.a0 = '0; b.a1 = '0; b.tid = '0; b.ef = '0;
    return b;
  endfunction

  function automatic logic in_window(logic en, logic [9:0] a);
    return en && (int'(a) >= 1016) && (int'(a) < 1024);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [9:0] a0, input logic [9:0] a1,
                      input logic [2:0] tid, input logic [7:0] ef, input logic rdy,
                      input logic rst);
    instr_t     cur, e, c;
    logic [1:0] exp_efm, c_io, exp_aio;
    logic [7:0] exp_wren;
    int         k;
    @(negedge clock);
    enable = en; addr = {a1, a0}; thread_id = tid; EmptyFull = ef; IO_ready = rdy;
    reset = rst;
    #1;
    e = hist[1];
    c = hist[2];
    exp_efm[0] = in_window(e.en, e.a0) ? e.ef[e.a0 % 8] : 1'b0;
    exp_efm[1] = in_window(e.en, e.a1) ? e.ef[e.a1 % 8] : 1'b0;
    c_io       = {in_window(c.en, c.a1), in_window(c.en, c.a0)};
    exp_aio    = rdy ? c_io : 2'b00;
    exp_wren   = '0;
    if (exp_aio[0]) exp_wren = exp_wren | (8'd1 << (c.a0 % 8));
    if (exp_aio[1]) exp_wren = exp_wren | (8'd1 << (c.a1 % 8));
    k = int'(c.tid);
    check("efm_a", 32'(efm_a), 32'(exp_efm));
    check("aio_a", 32'(aio_a), 32'(exp_aio));
    check("wren_a", 32'(wren_a), 32'(exp_wren));
    check("annul_a", 32'(cnt_out_a), cnt_a[k]);
    check("starved_a", 32'(starved_a), 32'(cnt_a[k] >= 8));
    check("efm_b", 32'(efm_b), 32'(exp_efm));
    check("wren_b", 32'(wren_b), 32'(exp_wren));
    check("annul_b", 32'(cnt_out_b), cnt_b[k]);
    check("starved_b", 32'(starved_b), 32'(cnt_b[k] >= 3));
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt_a[i] = 0;
        cnt_b[i] = 0;
      end
      for (int i = 0; i < 3; i++) hist[i] = bubble();
    end else begin
      if (c_io != 2'b00) begin
        if (rdy) begin
          cnt_a[k] = 0;
          cnt_b[k] = 0;
        end else begin
          if (cnt_a[k] < 15) cnt_a[k] = cnt_a[k] + 1;
          if (cnt_b[k] < 3) cnt_b[k] = cnt_b[k] + 1;
        end
      end
      cur.en = en; cur.a0 = a0; cur.a1 = a1; cur.tid = tid; cur.ef = ef;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = cur;
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 10'd0, 10'd0, 3'd0, 8'h00, rdy, 1'b0);
  endtask

  initial begin
    logic [9:0] ra0, ra1;
    reset = 1'b1; enable = 1'b0; addr = '0; thread_id = '0; EmptyFull = '0; IO_ready = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = bubble();
    for (int i = 0; i < 8; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
    repeat (2) @(posedge clock);

    // Reset state, with IO_ready high.
    idle(1'b1);
    idle(1'b1);

    // One I/O dest and one ordinary dest, all ports empty, committed.
    step(1'b1, 10'd1018, 10'd5, 3'd0, 8'h00, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Full port, annulled on thread 5.
    step(1'b1, 10'd1018, 10'd0, 3'd5, 8'h04, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Just outside the window.
    step(1'b1, 10'd100, 10'd1015, 3'd5, 8'hFF, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Window edges and two dests on one port.
    step(1'b1, 10'd1023, 10'd1016, 3'd1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 10'd1020, 10'd1020, 3'd2, 8'h00, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b1);

    // Thread 5 annulled back to back until it saturates, then succeeds.
    for (int i = 0; i < 6; i++) step(1'b1, 10'd1018, 10'd0, 3'd5, 8'h04, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Disabled instruction never looks like I/O.
    step(1'b0, 10'd1018, 10'd1018, 3'd3, 8'hFF, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Build up a count, then reset with an instruction in stage 2.
    step(1'b1, 10'd1019, 10'd0, 3'd6, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 10'd1019, 10'd0, 3'd6, 8'hFF, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    step(1'b1, 10'd1017, 10'd1022, 3'd6, 8'h00, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b0, 10'd0, 10'd0, 3'd0, 8'h00, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);
    // Read back every thread's counter through a non-I/O instruction.
    for (int t = 0; t < 8; t++) step(1'b0, 10'd0, 10'd0, 3'(t), 8'h00, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Randomised traffic biased into the window and toward a few threads.
    for (int n = 0; n < 600; n++) begin
      ra0 = ($urandom_range(0, 1) == 0) ? 10'(1016 + $urandom_range(0, 7)) : 10'($urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? 10'(1016 + $urandom_range(0, 7)) : 10'($urandom);
      step(1'($urandom_range(0, 4) != 0), ra0, ra1, 3'($urandom_range(0, 3)),
           8'($urandom), 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
